// File: rtl/memoria_ram_ctrl_if.sv
// memoria_ram_ctrl_if: command/response bundle between the register bank and the RAM responder
interface memoria_ram_ctrl_if #(parameter int DATA_W = 32, parameter int ADDR_W = 4);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        wr_rd;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              done;
  logic              busy;
  logic              err;
  modport master (output addr, wdata, wr_rd, input rdata, rdata_valid, done, busy, err);
  modport slave  (input addr, wdata, wr_rd, output rdata, rdata_valid, done, busy, err);
endinterface

// File: rtl/memoria_ram_ctrl.sv
// memoria_ram_ctrl: fixed-latency RAM responder servicing each command level exactly once
module memoria_ram_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  memoria_ram_ctrl_if.slave bus
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              wr_q, wr_d, rv_q, rv_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              accept, fire;
  assign accept = state_q == IDLE && ^bus.wr_rd;
  assign fire   = state_q == ACCESS && cnt_q == '0;
  // next state: HOLD absorbs the rest of the command level until it drops to idle
  always_comb begin
    state_d = state_q == IDLE   ? (accept ? ACCESS : (bus.wr_rd == 2'b11 ? HOLD : IDLE)) :
              state_q == ACCESS ? (fire ? HOLD : ACCESS) :
                                  (bus.wr_rd == 2'b00 ? IDLE : HOLD);
  end
  // next values of latched command, latency counter and registered outputs
  always_comb begin
    addr_d  = accept ? bus.addr : addr_q;
    wdata_d = accept ? bus.wdata : wdata_q;
    wr_d    = accept ? bus.wr_rd[1] : wr_q;
    cnt_d   = accept ? CW'(LATENCY - 1) : (state_q == ACCESS && !fire ? cnt_q - CW'(1) : cnt_q);
    rdata_d = fire && !wr_q ? mem_q[addr_q] : rdata_q;
    rv_d    = fire && !wr_q;
    done_d  = fire;
    err_d   = state_q == IDLE && bus.wr_rd == 2'b11;
  end
  // state and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      rv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      rv_q    <= rv_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  // storage array; a write only lands on the completing edge, so reset mid-access aborts it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (fire && wr_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rv_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_memoria_ram_ctrl.sv
// tb_memoria_ram_ctrl: scoreboard bench for the RAM responder
module tb_memoria_ram_ctrl;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  memoria_ram_ctrl_if #(.DATA_W(32), .ADDR_W(4)) bus ();
  memoria_ram_ctrl #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  typedef struct {logic [1:0] kind; logic [31:0] data; int cyc;} exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // monitor: every pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.done || bus.err || bus.rdata_valid)) begin
        if (q.size() == 0) chk("unexpected_pulse", {29'd0, bus.done, bus.rdata_valid, bus.err}, 32'd0);
        else begin
          e = q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("done", {31'd0, bus.done}, {31'd0, e.kind != 2'd3});
          chk("rdata_valid", {31'd0, bus.rdata_valid}, {31'd0, e.kind == 2'd1});
          chk("err", {31'd0, bus.err}, {31'd0, e.kind == 2'd3});
          if (e.kind == 2'd1) chk("rdata", bus.rdata, e.data);
        end
      end
    end
  end
  // kind equals the command code: 1 read, 2 write, 3 illegal
  task automatic do_op(input logic [1:0] op, input logic [3:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input int hold);
    @(negedge clk);
    bus.addr = a;
    bus.wdata = d;
    bus.wr_rd = op;
    q.push_back('{op, exp, op == 2'b11 ? cyc + 1 : cyc + 1 + LAT});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("busy_hold", {31'd0, bus.busy}, 32'd1);
    end
    bus.wr_rd = 2'b00;
    @(negedge clk);
    chk("busy_idle", {31'd0, bus.busy}, 32'd0);
  endtask
  initial begin
    bus.addr = '0;
    bus.wdata = '0;
    bus.wr_rd = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_flags", {28'd0, bus.done, bus.rdata_valid, bus.busy, bus.err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // write then read back with exact latency
    do_op(2'b10, 4'd3, 32'hDEADBEEF, 32'h0, LAT + 1);
    do_op(2'b01, 4'd3, 32'h0, 32'hDEADBEEF, LAT + 1);
    // long read level serviced once
    do_op(2'b01, 4'd5, 32'h0, 32'h0, 10);
    // illegal command, then addr 7 still unwritten
    do_op(2'b11, 4'd7, 32'h77777777, 32'h0, 1);
    do_op(2'b01, 4'd7, 32'h0, 32'h0, LAT + 1);
    // inputs change during access are ignored
    @(negedge clk);
    bus.addr = 4'd15;
    bus.wdata = 32'h12345678;
    bus.wr_rd = 2'b10;
    q.push_back('{2'd2, 32'h0, cyc + 1 + LAT});
    @(negedge clk);
    bus.addr = 4'd0;
    bus.wdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    bus.wr_rd = 2'b00;
    @(negedge clk);
    do_op(2'b01, 4'd0, 32'h0, 32'h0, LAT + 1);
    do_op(2'b01, 4'd15, 32'h0, 32'h12345678, LAT + 1);
    // reset during a write access aborts it
    @(negedge clk);
    bus.addr = 4'd9;
    bus.wdata = 32'hCAFEF00D;
    bus.wr_rd = 2'b10;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rdata", bus.rdata, 32'd0);
    chk("midrst_flags", {28'd0, bus.done, bus.rdata_valid, bus.busy, bus.err}, 32'd0);
    bus.wr_rd = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(2'b01, 4'd9, 32'h0, 32'h0, LAT + 1);
    // back-to-back writes separated by one idle cycle
    do_op(2'b10, 4'd1, 32'hA5A5A5A5, 32'h0, LAT + 1);
    do_op(2'b10, 4'd2, 32'h5A5A0001, 32'h0, LAT + 1);
    do_op(2'b01, 4'd1, 32'h0, 32'hA5A5A5A5, LAT + 1);
    do_op(2'b01, 4'd2, 32'h0, 32'h5A5A0001, LAT + 1);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
